mux_rr_sequencer: RTL and testbench

- Upstream sequencer for the 31:1 byte-wide selector mux. It arbitrates round-robin among 31 requesters and drives the mux select. It captures the returned mux byte into an output register and presents it downstream with a valid/ready handshake.
- One transfer per grant. It never drives a select value outside 0..NUM_IN-1.

---
 rtl/mux_pkg.sv | 19 +
 rtl/mux_rr_sequencer_if.sv | 23 ++
 rtl/mux_rr_sequencer_rr_pick.sv | 45 ++++
 rtl/mux_rr_sequencer.sv | 89 ++++++++
 tb/tb_mux_rr_sequencer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared constants, FSM state type and index helper for the round-robin mux sequencer.
package mux_pkg;

   localparam int NUM_IN = 31;
   localparam int DATA_W = 8;
   localparam int SEL_W  = 5;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      VALID
   } state_t;

   // Wraps at NUM_IN-1 so the select never reaches the mux default code.
   function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
      return (idx == SEL_W'(NUM_IN - 1)) ? '0 : idx + SEL_W'(1);
   endfunction

endpackage

// File: rtl/mux_rr_sequencer_if.sv
// Requester, mux and downstream signals of the sequencer bundled as one interface.
interface mux_rr_sequencer_if import mux_pkg::*; ();

   logic [NUM_IN-1:0] req;
   logic [NUM_IN-1:0] ack;
   logic [SEL_W-1:0]  sel;
   logic [DATA_W-1:0] mux_data;
   logic [DATA_W-1:0] dout;
   logic [SEL_W-1:0]  dout_src;
   logic              dout_valid;
   logic              dout_ready;

   modport master (
      input  req, mux_data, dout_ready,
      output ack, sel, dout, dout_src, dout_valid
   );

   modport slave (
      output req, mux_data, dout_ready,
      input  ack, sel, dout, dout_src, dout_valid
   );

endinterface

// File: rtl/mux_rr_sequencer_rr_pick.sv
// Combinational round-robin picker: first set request at or above start, wrapping modulo NUM_IN.
module rr_pick import mux_pkg::*; (
   input  logic [NUM_IN-1:0] req,
   input  logic [SEL_W-1:0]  start,
   output logic [SEL_W-1:0]  winner,
   output logic              any
);

   localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_IN);

   logic [NUM_IN-1:0] rot;
   logic [NUM_IN-1:0] none_below;
   logic [NUM_IN-1:0] first;
   logic [SEL_W-1:0]  offset;
   logic [SEL_W:0]    sum;

   // Doubling the vector makes the rotate a plain shift with the wrap built in.
   assign rot = NUM_IN'({req, req} >> start);

   assign none_below[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 1; gi < NUM_IN; gi++) begin : g_chain
         assign none_below[gi] = none_below[gi-1] & ~rot[gi-1];
      end
      for (gi = 0; gi < NUM_IN; gi++) begin : g_first
         assign first[gi] = rot[gi] & none_below[gi];
      end
   endgenerate

   always_comb begin
      offset = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (first[i]) begin
            offset = offset | SEL_W'(i);
         end
      end
   end

   assign sum    = {1'b0, start} + {1'b0, offset};
   assign winner = (sum >= NUM_IN_W) ? SEL_W'(sum - NUM_IN_W) : sum[SEL_W-1:0];
   assign any    = |req;

endmodule

// File: rtl/mux_rr_sequencer.sv
// Round-robin sequencer driving a 31:1 byte mux select and presenting the captured byte downstream.
module mux_rr_sequencer import mux_pkg::*; (
   input  logic               clk,
   input  logic               reset,
   mux_rr_sequencer_if.master bus
);

   state_t            state_reg;
   logic [SEL_W-1:0]  sel_reg;
   logic [SEL_W-1:0]  dout_src_reg;
   logic [SEL_W-1:0]  last_grant_reg;
   logic [DATA_W-1:0] dout_reg;
   logic              dout_valid_reg;
   logic [NUM_IN-1:0] ack_reg;

   logic [NUM_IN-1:0] pick_req_next;
   logic [SEL_W-1:0]  pick_start_next;
   logic [SEL_W-1:0]  winner;
   logic              any;

   // In VALID the source being retired has already been acked, so it sits out this round.
   always_comb begin
      pick_req_next   = bus.req;
      pick_start_next = next_idx(last_grant_reg);
      if (state_reg == VALID) begin
         pick_req_next   = bus.req & ~(NUM_IN'(1) << dout_src_reg);
         pick_start_next = next_idx(dout_src_reg);
      end
   end

   rr_pick u_pick (
      .req    (pick_req_next),
      .start  (pick_start_next),
      .winner (winner),
      .any    (any)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         sel_reg        <= '0;
         dout_src_reg   <= '0;
         last_grant_reg <= SEL_W'(NUM_IN - 1);
         dout_reg       <= '0;
         dout_valid_reg <= 1'b0;
         ack_reg        <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (any) begin
                  sel_reg   <= winner;
                  ack_reg   <= NUM_IN'(1) << winner;
                  state_reg <= CAPTURE;
               end
            end
            CAPTURE: begin
               dout_reg       <= bus.mux_data;
               dout_src_reg   <= sel_reg;
               dout_valid_reg <= 1'b1;
               ack_reg        <= '0;
               state_reg      <= VALID;
            end
            VALID: begin
               if (bus.dout_ready) begin
                  last_grant_reg <= dout_src_reg;
                  dout_valid_reg <= 1'b0;
                  if (any) begin
                     sel_reg   <= winner;
                     ack_reg   <= NUM_IN'(1) << winner;
                     state_reg <= CAPTURE;
                  end else begin
                     state_reg <= IDLE;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.sel        = sel_reg;
   assign bus.ack        = ack_reg;
   assign bus.dout       = dout_reg;
   assign bus.dout_src   = dout_src_reg;
   assign bus.dout_valid = dout_valid_reg;

endmodule

// File: tb/tb_mux_rr_sequencer.sv
// Bench for mux_rr_sequencer: vector table, directed corner sequences and a random run against a transaction model.
module tb_mux_rr_sequencer;
   import mux_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mux_rr_sequencer_if bus();

   mux_rr_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   // Each mux input carries a distinct code; the unused code reads zero.
   function automatic logic [7:0] mux_byte(input int i);
      return (i < NUM_IN) ? 8'(8'hA0 + i) : 8'h00;
   endfunction

   assign bus.mux_data = mux_byte(int'(bus.sel));

   int checks = 0;
   int errors = 0;

   int                m_phase = 0;
   int                m_sel = 0;
   int                m_src = 0;
   int                m_last = NUM_IN - 1;
   logic [7:0]        m_dout = 8'h00;
   logic              m_valid = 1'b0;
   logic [NUM_IN-1:0] m_ack = '0;

   typedef struct {
      logic              rst;
      logic [NUM_IN-1:0] req;
      logic              rdy;
      logic [4:0]        sel;
      logic [NUM_IN-1:0] ack;
      logic              valid;
      logic [7:0]        dout;
      logic [4:0]        src;
   } vec_t;

   localparam logic [NUM_IN-1:0] R4 = 31'h4000_3001;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int rr_search(input logic [NUM_IN-1:0] r, input int after);
      for (int k = 1; k <= NUM_IN; k++) begin
         int idx;
         idx = (after + k) % NUM_IN;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   // Transaction-level model of one clock edge.
   task automatic model_edge(input logic r, input logic [NUM_IN-1:0] rq, input logic rdy);
      int w;
      if (r) begin
         m_phase = 0; m_sel = 0; m_src = 0; m_dout = 8'h00;
         m_valid = 1'b0; m_ack = '0; m_last = NUM_IN - 1;
      end else if (m_phase == 0) begin
         w = rr_search(rq, m_last);
         if (w >= 0) begin
            m_sel = w; m_ack = NUM_IN'(1) << w; m_phase = 1;
         end
      end else if (m_phase == 1) begin
         m_dout = mux_byte(m_sel); m_src = m_sel; m_valid = 1'b1;
         m_ack = '0; m_phase = 2;
      end else if (rdy) begin
         $display("xfer src=%0d dout=0x%02h", m_src, m_dout);
         m_last = m_src;
         m_valid = 1'b0;
         w = rr_search(rq & ~(NUM_IN'(1) << m_src), m_src);
         if (w >= 0) begin
            m_sel = w; m_ack = NUM_IN'(1) << w; m_phase = 1;
         end else begin
            m_phase = 0;
         end
      end
   endtask

   task automatic step(input logic r, input logic [NUM_IN-1:0] rq, input logic rdy);
      reset = r;
      bus.req = rq;
      bus.dout_ready = rdy;
      @(posedge clk);
      model_edge(r, rq, rdy);
      @(negedge clk);
      chk("model_sel", bus.sel, m_sel);
      chk("model_ack", bus.ack, m_ack);
      chk("model_valid", bus.dout_valid, m_valid);
      chk("model_dout", bus.dout, m_dout);
      chk("model_src", bus.dout_src, m_src);
      chk("sel_range", bus.sel < NUM_IN, 1);
   endtask

   function automatic vec_t mk(input logic rst, input logic [NUM_IN-1:0] req, input logic rdy,
                               input int sel, input int ack_idx, input logic valid,
                               input logic [7:0] dout, input int src);
      vec_t v;
      v.rst = rst; v.req = req; v.rdy = rdy; v.sel = 5'(sel);
      v.ack = (ack_idx < 0) ? '0 : NUM_IN'(1) << ack_idx;
      v.valid = valid; v.dout = dout; v.src = 5'(src);
      return v;
   endfunction

   initial begin
      vec_t              tbl[16];
      logic [NUM_IN-1:0] pend;
      int                waits[NUM_IN];
      int                worst;
      logic              r;

      tbl[0]  = mk(1, '0,              1,  0, -1, 0, 8'h00,  0);
      tbl[1]  = mk(0, NUM_IN'(1) << 5, 1,  5,  5, 0, 8'h00,  0);
      tbl[2]  = mk(0, '0,              1,  5, -1, 1, 8'hA5,  5);
      tbl[3]  = mk(0, '0,              1,  5, -1, 0, 8'hA5,  5);
      tbl[4]  = mk(0, '0,              1,  5, -1, 0, 8'hA5,  5);
      tbl[5]  = mk(1, '0,              1,  0, -1, 0, 8'h00,  0);
      tbl[6]  = mk(0, R4,              1,  0,  0, 0, 8'h00,  0);
      tbl[7]  = mk(0, R4,              1,  0, -1, 1, 8'hA0,  0);
      tbl[8]  = mk(0, R4,              1, 12, 12, 0, 8'hA0,  0);
      tbl[9]  = mk(0, R4,              1, 12, -1, 1, 8'hAC, 12);
      tbl[10] = mk(0, R4,              1, 13, 13, 0, 8'hAC, 12);
      tbl[11] = mk(0, R4,              1, 13, -1, 1, 8'hAD, 13);
      tbl[12] = mk(0, R4,              1, 30, 30, 0, 8'hAD, 13);
      tbl[13] = mk(0, R4,              1, 30, -1, 1, 8'hBE, 30);
      tbl[14] = mk(0, R4,              1,  0,  0, 0, 8'hBE, 30);
      tbl[15] = mk(0, R4,              1,  0, -1, 1, 8'hA0,  0);

      bus.req = '0;
      bus.dout_ready = 1'b0;

      // Reset and idle.
      step(1, '0, 0);
      step(1, '0, 0);
      for (int k = 0; k < 10; k++) begin
         step(0, '0, 1);
         chk("idle_sel", bus.sel, 0);
         chk("idle_ack", bus.ack, 0);
         chk("idle_valid", bus.dout_valid, 0);
      end

      // Vector table: single request latency, then grant order 0,12,13,30,0.
      for (int k = 0; k < 16; k++) begin
         step(tbl[k].rst, tbl[k].req, tbl[k].rdy);
         chk($sformatf("vec%0d_sel", k), bus.sel, tbl[k].sel);
         chk($sformatf("vec%0d_ack", k), bus.ack, tbl[k].ack);
         chk($sformatf("vec%0d_valid", k), bus.dout_valid, tbl[k].valid);
         chk($sformatf("vec%0d_dout", k), bus.dout, tbl[k].dout);
         chk($sformatf("vec%0d_src", k), bus.dout_src, tbl[k].src);
      end

      // Wrap from 30 to 0, then on to 29.
      step(1, '0, 0);
      step(0, NUM_IN'(1) << 30, 1);
      chk("wrap_first", bus.sel, 30);
      step(0, (NUM_IN'(1) << 29) | NUM_IN'(1), 1);
      chk("wrap_dout", bus.dout, 8'hBE);
      step(0, (NUM_IN'(1) << 29) | NUM_IN'(1), 1);
      chk("wrap_to_0", bus.sel, 0);
      step(0, NUM_IN'(1) << 29, 1);
      step(0, NUM_IN'(1) << 29, 1);
      chk("wrap_then_29", bus.sel, 29);

      // Downstream stall with requests toggling.
      step(1, '0, 0);
      step(0, NUM_IN'(1) << 3, 0);
      step(0, '0, 0);
      for (int k = 0; k < 7; k++) begin
         step(0, NUM_IN'($urandom), 0);
         chk("stall_dout", bus.dout, 8'hA3);
         chk("stall_src", bus.dout_src, 3);
         chk("stall_sel", bus.sel, 3);
         chk("stall_ack", bus.ack, 0);
         chk("stall_valid", bus.dout_valid, 1);
      end
      step(0, NUM_IN'(1) << 7, 1);
      chk("release_sel", bus.sel, 7);
      chk("release_ack", bus.ack, NUM_IN'(1) << 7);

      // Reset in CAPTURE and in VALID.
      step(1, '0, 0);
      step(0, NUM_IN'(1) << 9, 1);
      step(1, NUM_IN'(1) << 9, 1);
      chk("rst_cap_sel", bus.sel, 0);
      chk("rst_cap_ack", bus.ack, 0);
      chk("rst_cap_valid", bus.dout_valid, 0);
      chk("rst_cap_dout", bus.dout, 0);
      step(0, (NUM_IN'(1) << 4) | (NUM_IN'(1) << 20), 0);
      chk("rst_cap_regrant", bus.sel, 4);
      step(0, (NUM_IN'(1) << 4) | (NUM_IN'(1) << 20), 0);
      chk("pre_rst_valid", bus.dout_valid, 1);
      step(1, (NUM_IN'(1) << 4) | (NUM_IN'(1) << 20), 0);
      chk("rst_val_valid", bus.dout_valid, 0);
      chk("rst_val_src", bus.dout_src, 0);
      chk("rst_val_dout", bus.dout, 0);
      step(0, (NUM_IN'(1) << 4) | (NUM_IN'(1) << 20), 1);
      chk("rst_val_regrant", bus.sel, 4);

      // Random traffic with level-held requests released on ack.
      step(1, '0, 0);
      pend = '0;
      for (int i = 0; i < NUM_IN; i++) waits[i] = 0;
      for (int c = 0; c < 3000; c++) begin
         r = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < NUM_IN; i++) begin
            if (!pend[i] && $urandom_range(0, 7) == 0) begin
               pend[i] = 1'b1;
               waits[i] = 0;
            end
         end
         step(r, pend, $urandom_range(0, 3) != 0);
         if (r) begin
            for (int i = 0; i < NUM_IN; i++) waits[i] = 0;
         end else if (bus.ack != '0) begin
            worst = 0;
            for (int i = 0; i < NUM_IN; i++) begin
               if (bus.ack[i]) begin
                  pend[i] = 1'b0;
               end else if (pend[i]) begin
                  waits[i]++;
                  if (waits[i] > worst) worst = waits[i];
               end
            end
            chk("fairness", worst <= NUM_IN - 1, 1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
